// File: rtl/pipe_pkg.sv
// Shared types and constants for the IF/ID pipeline boundary.
package pipe_pkg;

  // Default field widths of the IF/ID payload.
  localparam int IF_ID_PC_W    = 32;
  localparam int IF_ID_INSTR_W = 32;

  // Bubble instruction presented to decode when nothing valid is held.
  localparam logic [IF_ID_INSTR_W-1:0] DEFAULT_NOP_INSTR = {IF_ID_INSTR_W{1'b0}};

  // Occupancy state of the 2-entry skid; encoding equals the entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  // One fetched PC/instruction pair.
  typedef struct packed {
    logic [IF_ID_PC_W-1:0]    pc;
    logic [IF_ID_INSTR_W-1:0] instr;
  } if_id_t;

endpackage

// File: rtl/skid_buffer2.sv
// Generic 2-entry valid/ready skid buffer with flush. All outputs come
// straight from flops; in_ready never depends combinationally on out_ready.
// When the buffer holds nothing, the head register is loaded with
// EMPTY_DATA so stale payload is never visible downstream.
module skid_buffer2
  import pipe_pkg::*;
#(
  parameter int             W          = 64,
  parameter logic [W-1:0]   EMPTY_DATA = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occupancy
);

  state_e       state_r;
  logic [W-1:0] main_r;
  logic [W-1:0] skid_r;
  logic         in_ready_r;
  logic         out_valid_r;
  logic         in_fire_s;
  logic         out_fire_s;

  assign in_fire_s  = in_valid & in_ready_r;
  assign out_fire_s = out_valid_r & out_ready;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = main_r;
  assign occupancy = state_r;

  // Occupancy FSM: updates state, head/skid storage and registered handshake flags.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_r     <= EMPTY;
      main_r      <= EMPTY_DATA;
      skid_r      <= {W{1'b0}};
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_fire_s) begin
            state_r     <= ONE;
            main_r      <= in_data;
            out_valid_r <= 1'b1;
            in_ready_r  <= 1'b1;
          end
        end
        ONE: begin
          if (in_fire_s && out_fire_s) begin
            main_r <= in_data;
          end else if (in_fire_s) begin
            // Decode stalled: park the new entry behind the head.
            state_r    <= TWO;
            skid_r     <= in_data;
            in_ready_r <= 1'b0;
          end else if (out_fire_s) begin
            state_r     <= EMPTY;
            main_r      <= EMPTY_DATA;
            out_valid_r <= 1'b0;
          end
        end
        TWO: begin
          if (out_fire_s) begin
            state_r    <= ONE;
            main_r     <= skid_r;
            skid_r     <= {W{1'b0}};
            in_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= EMPTY;
          main_r      <= EMPTY_DATA;
          skid_r      <= {W{1'b0}};
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline boundary: valid/ready handshake backed by a 2-entry skid
// buffer. An empty stage presents pc=0 and the configured NOP bubble.
module if_id_skid_stage #(
  parameter int                 PC_W      = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = {INSTR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [1:0]         occupancy
);

  localparam int W = PC_W + INSTR_W;
  // Bubble payload loaded into the head register whenever it is empty, so
  // the invalid-head masking is carried by the flops themselves.
  localparam logic [W-1:0] BUBBLE = {{PC_W{1'b0}}, NOP_INSTR};

  logic [W-1:0] in_data_s;
  logic [W-1:0] out_data_s;

  assign in_data_s = {in_pc, in_instr};
  assign out_pc    = out_data_s[W-1:INSTR_W];
  assign out_instr = out_data_s[INSTR_W-1:0];

  skid_buffer2 #(
    .W          (W),
    .EMPTY_DATA (BUBBLE)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data_s),
    .occupancy (occupancy)
  );

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Self-checking bench for if_id_skid_stage: a queue-based model of a
// 2-deep FIFO plus directed literal checks and randomized traffic.
module tb_if_id_skid_stage;
  import pipe_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [1:0]  occupancy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  if_id_t mq[$];

  if_id_skid_stage #(
    .PC_W      (32),
    .INSTR_W   (32),
    .NOP_INSTR (NOP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .occupancy (occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of capacity 2, flushed by rst/flush.
  always @(posedge clk) begin
    bit m_valid;
    bit m_ready;
    m_valid = (mq.size() > 0);
    m_ready = (mq.size() < 2);
    if (rst || flush) begin
      mq.delete();
    end else begin
      if (m_valid && out_ready) void'(mq.pop_front());
      if (in_valid && m_ready) mq.push_back('{pc: in_pc, instr: in_instr});
    end
  end

  // Compare process: DUT outputs versus the model every cycle once reset is done.
  always @(negedge clk) begin
    if (chk_en) begin
      if (mq.size() > 0) begin
        chk("m_out_valid", {31'd0, out_valid}, 32'd1);
        chk("m_out_pc", out_pc, mq[0].pc);
        chk("m_out_instr", out_instr, mq[0].instr);
      end else begin
        chk("m_out_valid", {31'd0, out_valid}, 32'd0);
        chk("m_out_pc", out_pc, 32'd0);
        chk("m_out_instr", out_instr, NOP);
      end
      chk("m_in_ready", {31'd0, in_ready}, (mq.size() < 2) ? 32'd1 : 32'd0);
      chk("m_occupancy", {30'd0, occupancy}, mq.size());
    end
  end

  task automatic drive(input logic r, input logic f, input logic iv,
                       input logic [31:0] pc, input logic [31:0] ins, input logic ordy);
    rst       = r;
    flush     = f;
    in_valid  = iv;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = ordy;
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'hBAD0_BAD0, ordy);
  endtask

  task automatic lit(input string tag, input logic v, input logic [31:0] pc,
                     input logic [31:0] ins, input logic rdy, input logic [1:0] occ);
    chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, "_pc"}, out_pc, pc);
    chk({tag, "_instr"}, out_instr, ins);
    chk({tag, "_ready"}, {31'd0, in_ready}, {31'd0, rdy});
    chk({tag, "_occ"}, {30'd0, occupancy}, {30'd0, occ});
  endtask

  initial begin
    // Reset for two cycles.
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    chk_en = 1'b1;
    lit("reset", 1'b0, 32'd0, NOP, 1'b1, 2'd0);

    // Streaming with decode always ready.
    drive(1'b0, 1'b0, 1'b1, 32'h100, 32'hA, 1'b1);
    lit("stream0", 1'b1, 32'h100, 32'hA, 1'b1, 2'd1);
    drive(1'b0, 1'b0, 1'b1, 32'h104, 32'hB, 1'b1);
    lit("stream1", 1'b1, 32'h104, 32'hB, 1'b1, 2'd1);
    idle(1'b1);
    lit("stream_end", 1'b0, 32'd0, NOP, 1'b1, 2'd0);

    // Stall fill, refused third push, then drain.
    drive(1'b0, 1'b0, 1'b1, 32'h200, 32'h1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'h204, 32'h2, 1'b0);
    lit("fill2", 1'b1, 32'h200, 32'h1, 1'b0, 2'd2);
    drive(1'b0, 1'b0, 1'b1, 32'h208, 32'h3, 1'b0);
    lit("refuse", 1'b1, 32'h200, 32'h1, 1'b0, 2'd2);
    idle(1'b1);
    lit("drain1", 1'b1, 32'h204, 32'h2, 1'b1, 2'd1);
    idle(1'b1);
    lit("drain2", 1'b0, 32'd0, NOP, 1'b1, 2'd0);

    // Flush while full, with a concurrent push.
    drive(1'b0, 1'b0, 1'b1, 32'h250, 32'h5, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'h260, 32'h6, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 32'h300, 32'h9, 1'b0);
    lit("flush_two", 1'b0, 32'd0, NOP, 1'b1, 2'd0);
    idle(1'b1);
    lit("flush_after", 1'b0, 32'd0, NOP, 1'b1, 2'd0);

    // Simultaneous push and pop in ONE.
    drive(1'b0, 1'b0, 1'b1, 32'h400, 32'h40, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'h404, 32'h44, 1'b1);
    lit("simul", 1'b1, 32'h404, 32'h44, 1'b1, 2'd1);
    idle(1'b1);
    lit("simul_end", 1'b0, 32'd0, NOP, 1'b1, 2'd0);

    // Flush wins over simultaneous in_fire and out_fire.
    drive(1'b0, 1'b0, 1'b1, 32'h410, 32'h41, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 32'h414, 32'h42, 1'b1);
    lit("flush_both", 1'b0, 32'd0, NOP, 1'b1, 2'd0);

    // Mid-stream reset while full, then resume.
    drive(1'b0, 1'b0, 1'b1, 32'h480, 32'h8, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'h484, 32'h9, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 32'h488, 32'hA, 1'b0);
    lit("midreset", 1'b0, 32'd0, NOP, 1'b1, 2'd0);
    drive(1'b0, 1'b0, 1'b1, 32'h500, 32'h50, 1'b1);
    lit("resume0", 1'b1, 32'h500, 32'h50, 1'b1, 2'd1);
    drive(1'b0, 1'b0, 1'b1, 32'h504, 32'h54, 1'b1);
    lit("resume1", 1'b1, 32'h504, 32'h54, 1'b1, 2'd1);
    idle(1'b1);

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0,
            $urandom, $urandom,
            ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1);
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
